// File: rtl/tx_buf_ptr_store_pkg.sv
// Shared types and default sizing for the TX buffer pointer store.
package tx_buf_ptr_store_pkg;

    localparam int TX_PAYLOAD_PTR_W    = 10;
    localparam int FLOWID_W            = 4;
    localparam int MAX_FLOW_CNT        = 16;
    localparam int NUM_TX_PTR_RD_PORTS = 2;

    typedef struct packed {
        logic [TX_PAYLOAD_PTR_W:0] head;
        logic [TX_PAYLOAD_PTR_W:0] tail;
    } buf_ptr_pair_t;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } init_state_t;

endpackage

// File: rtl/tx_buf_ptr_store_bank.sv
// Pointer bank: 1R1W sync-read {head, tail} store with per-half write enables.
// Latency: read data valid the cycle after rd_en (read-old on address collision).
// Backpressure: none; rd_head/rd_tail hold until the next rd_en.
module tx_buf_ptr_store_bank #(
    parameter int FLOW_W = 4,
    parameter int PTR_W  = 10,
    parameter int ELS    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              head_wr_en,
    input  logic [FLOW_W-1:0] head_wr_addr,
    input  logic [PTR_W:0]    head_wr_data,
    input  logic              tail_wr_en,
    input  logic [FLOW_W-1:0] tail_wr_addr,
    input  logic [PTR_W:0]    tail_wr_data,
    input  logic              rd_en,
    input  logic [FLOW_W-1:0] rd_addr,
    output logic [PTR_W:0]    rd_head,
    output logic [PTR_W:0]    rd_tail
);

    typedef struct packed {
        logic [PTR_W:0] head;
        logic [PTR_W:0] tail;
    } pair_t;

    pair_t mem [0:ELS-1];

    // Halves carry their own address so head and tail updates to different flows land together.
    always_ff @(posedge clk) begin
        if (head_wr_en) mem[head_wr_addr].head <= head_wr_data;
        if (tail_wr_en) mem[tail_wr_addr].tail <= tail_wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_head <= '0;
            rd_tail <= '0;
        end else if (rd_en) begin
            rd_head <= mem[rd_addr].head;
            rd_tail <= mem[rd_addr].tail;
        end
    end

endmodule

// File: rtl/tx_buf_ptr_store.sv
// Per-flow TX head/tail pointer store with NUM_RD_PORTS read channels, used/free calc and write forwarding.
// Latency: read response 1 cycle after acceptance; writes visible to same-cycle reads.
// Backpressure: per-channel valid/ready; held responses stay stable except for forwarded writes.
module tx_buf_ptr_store
    import tx_buf_ptr_store_pkg::*;
#(
    parameter int NUM_RD_PORTS = NUM_TX_PTR_RD_PORTS,
    parameter int FLOW_W       = FLOWID_W,
    parameter int PTR_W        = TX_PAYLOAD_PTR_W,
    parameter int ELS          = MAX_FLOW_CNT
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              init_done,
    input  logic [NUM_RD_PORTS-1:0]           rd_req_val,
    output logic [NUM_RD_PORTS-1:0]           rd_req_rdy,
    input  logic [NUM_RD_PORTS*FLOW_W-1:0]    rd_req_addr,
    output logic [NUM_RD_PORTS-1:0]           rd_resp_val,
    input  logic [NUM_RD_PORTS-1:0]           rd_resp_rdy,
    output logic [NUM_RD_PORTS*FLOW_W-1:0]    rd_resp_addr,
    output logic [NUM_RD_PORTS*(PTR_W+1)-1:0] rd_resp_head,
    output logic [NUM_RD_PORTS*(PTR_W+1)-1:0] rd_resp_tail,
    output logic [NUM_RD_PORTS*(PTR_W+1)-1:0] rd_resp_used,
    output logic [NUM_RD_PORTS*(PTR_W+1)-1:0] rd_resp_free,
    input  logic                              head_wr_val,
    output logic                              head_wr_rdy,
    input  logic [FLOW_W-1:0]                 head_wr_addr,
    input  logic [PTR_W:0]                    head_wr_data,
    input  logic                              tail_wr_val,
    output logic                              tail_wr_rdy,
    input  logic [FLOW_W-1:0]                 tail_wr_addr,
    input  logic [PTR_W:0]                    tail_wr_data,
    input  logic                              new_flow_val,
    output logic                              new_flow_rdy,
    input  logic [FLOW_W-1:0]                 new_flow_flowid,
    input  logic [PTR_W:0]                    new_flow_head,
    input  logic [PTR_W:0]                    new_flow_tail,
    output logic                              err_overflow
);

    localparam int             PW  = PTR_W + 1;
    localparam logic [PW-1:0]  CAP = {1'b1, {PTR_W{1'b0}}};

    init_state_t       state, state_nxt;
    logic [FLOW_W-1:0] cnt, cnt_nxt;
    logic              sweep_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_done <= (state == ST_READY);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_wr  = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_wr = 1'b1;
                if (cnt == FLOW_W'(ELS - 1)) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign new_flow_rdy = init_done;
    assign head_wr_rdy  = init_done & ~new_flow_val;
    assign tail_wr_rdy  = init_done & ~new_flow_val;

    logic              h_en, t_en;
    logic [FLOW_W-1:0] h_addr, t_addr;
    logic [PW-1:0]     h_dat, t_dat;

    // Committed head/tail writes; these feed every bank and every forwarding path.
    always_comb begin
        h_en   = 1'b0;
        t_en   = 1'b0;
        h_addr = head_wr_addr;
        t_addr = tail_wr_addr;
        h_dat  = head_wr_data;
        t_dat  = tail_wr_data;
        if (sweep_wr) begin
            h_en   = 1'b1;
            t_en   = 1'b1;
            h_addr = cnt;
            t_addr = cnt;
            h_dat  = '0;
            t_dat  = '0;
        end else if (new_flow_val && new_flow_rdy) begin
            h_en   = 1'b1;
            t_en   = 1'b1;
            h_addr = new_flow_flowid;
            t_addr = new_flow_flowid;
            h_dat  = new_flow_head;
            t_dat  = new_flow_tail;
        end else begin
            h_en = head_wr_val & head_wr_rdy;
            t_en = tail_wr_val & tail_wr_rdy;
        end
    end

    logic [NUM_RD_PORTS-1:0] ovf;

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_ch
        logic [FLOW_W-1:0] req_addr, addr;
        logic              acc, vld, h_ovr, t_ovr;
        logic [PW-1:0]     q_head, q_tail, h_reg, t_reg, eff_head, eff_tail, used, free;

        assign req_addr      = rd_req_addr[g*FLOW_W +: FLOW_W];
        assign rd_req_rdy[g] = init_done & (~vld | rd_resp_rdy[g]);
        assign acc           = rd_req_val[g] & rd_req_rdy[g];

        tx_buf_ptr_store_bank #(.FLOW_W(FLOW_W), .PTR_W(PTR_W), .ELS(ELS)) u_bank (
            .clk          (clk),
            .rst          (rst),
            .head_wr_en   (h_en),
            .head_wr_addr (h_addr),
            .head_wr_data (h_dat),
            .tail_wr_en   (t_en),
            .tail_wr_addr (t_addr),
            .tail_wr_data (t_dat),
            .rd_en        (acc),
            .rd_addr      (req_addr),
            .rd_head      (q_head),
            .rd_tail      (q_tail)
        );

        // Overlay registers shadow bank data whenever a write to this flow commits after the bank read.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld   <= 1'b0;
                addr  <= '0;
                h_ovr <= 1'b0;
                t_ovr <= 1'b0;
                h_reg <= '0;
                t_reg <= '0;
            end else if (acc) begin
                vld   <= 1'b1;
                addr  <= req_addr;
                h_ovr <= h_en && (h_addr == req_addr);
                t_ovr <= t_en && (t_addr == req_addr);
                h_reg <= h_dat;
                t_reg <= t_dat;
            end else begin
                if (rd_resp_rdy[g]) vld <= 1'b0;
                if (vld && h_en && (h_addr == addr)) begin
                    h_ovr <= 1'b1;
                    h_reg <= h_dat;
                end
                if (vld && t_en && (t_addr == addr)) begin
                    t_ovr <= 1'b1;
                    t_reg <= t_dat;
                end
            end
        end

        assign eff_head = h_ovr ? h_reg : q_head;
        assign eff_tail = t_ovr ? t_reg : q_tail;
        assign used     = eff_tail - eff_head;
        assign free     = CAP - used;
        assign ovf[g]   = vld & (used > CAP);

        assign rd_resp_val[g]                   = vld;
        assign rd_resp_addr[g*FLOW_W +: FLOW_W] = vld ? addr     : '0;
        assign rd_resp_head[g*PW +: PW]         = vld ? eff_head : '0;
        assign rd_resp_tail[g*PW +: PW]         = vld ? eff_tail : '0;
        assign rd_resp_used[g*PW +: PW]         = vld ? used     : '0;
        assign rd_resp_free[g*PW +: PW]         = vld ? free     : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      err_overflow <= 1'b0;
        else if (|ovf) err_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_tx_buf_ptr_store.sv
// Bench for tx_buf_ptr_store: directed scenarios plus randomized traffic against a per-flow pointer model.
module tb_tx_buf_ptr_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [1:0]  rd_req_val, rd_req_rdy, rd_resp_val, rd_resp_rdy;
    logic [7:0]  rd_req_addr, rd_resp_addr;
    logic [21:0] rd_resp_head, rd_resp_tail, rd_resp_used, rd_resp_free;
    logic        head_wr_val, head_wr_rdy, tail_wr_val, tail_wr_rdy, new_flow_val, new_flow_rdy;
    logic [3:0]  head_wr_addr, tail_wr_addr, new_flow_flowid;
    logic [10:0] head_wr_data, tail_wr_data, new_flow_head, new_flow_tail;
    logic        err_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [10:0] mh [16];
    logic [10:0] mt [16];
    logic        err_exp = 1'b0;

    tx_buf_ptr_store #(.NUM_RD_PORTS(2), .FLOW_W(4), .PTR_W(10), .ELS(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .init_done       (init_done),
        .rd_req_val      (rd_req_val),
        .rd_req_rdy      (rd_req_rdy),
        .rd_req_addr     (rd_req_addr),
        .rd_resp_val     (rd_resp_val),
        .rd_resp_rdy     (rd_resp_rdy),
        .rd_resp_addr    (rd_resp_addr),
        .rd_resp_head    (rd_resp_head),
        .rd_resp_tail    (rd_resp_tail),
        .rd_resp_used    (rd_resp_used),
        .rd_resp_free    (rd_resp_free),
        .head_wr_val     (head_wr_val),
        .head_wr_rdy     (head_wr_rdy),
        .head_wr_addr    (head_wr_addr),
        .head_wr_data    (head_wr_data),
        .tail_wr_val     (tail_wr_val),
        .tail_wr_rdy     (tail_wr_rdy),
        .tail_wr_addr    (tail_wr_addr),
        .tail_wr_data    (tail_wr_data),
        .new_flow_val    (new_flow_val),
        .new_flow_rdy    (new_flow_rdy),
        .new_flow_flowid (new_flow_flowid),
        .new_flow_head   (new_flow_head),
        .new_flow_tail   (new_flow_tail),
        .err_overflow    (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] get_resp(int ch);
        return {rd_resp_val[ch], rd_resp_addr[ch*4 +: 4], rd_resp_head[ch*11 +: 11],
                rd_resp_tail[ch*11 +: 11], rd_resp_used[ch*11 +: 11], rd_resp_free[ch*11 +: 11]};
    endfunction

    // Expected response for a flow: occupancy is tail-head modulo 2^11, free is 2^10 minus that.
    function automatic logic [48:0] exp_resp(int f);
        logic [10:0] u;
        u = mt[f] - mh[f];
        return {1'b1, 4'(f), mh[f], mt[f], u, 11'h400 - u};
    endfunction

    function automatic logic [10:0] m_used(int f);
        return mt[f] - mh[f];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mh[i] = '0;
            mt[i] = '0;
        end
    endtask

    task automatic do_new_flow(input logic [3:0] f, input logic [10:0] h, input logic [10:0] t);
        new_flow_val = 1'b1; new_flow_flowid = f; new_flow_head = h; new_flow_tail = t;
        @(posedge clk); #1;
        new_flow_val = 1'b0;
        mh[f] = h; mt[f] = t;
    endtask

    task automatic do_tail_wr(input logic [3:0] f, input logic [10:0] t);
        tail_wr_val = 1'b1; tail_wr_addr = f; tail_wr_data = t;
        @(posedge clk); #1;
        tail_wr_val = 1'b0;
        mt[f] = t;
    endtask

    task automatic do_read(input int ch, input logic [3:0] f, output logic [48:0] got);
        rd_req_val[ch] = 1'b1;
        rd_req_addr[ch*4 +: 4] = f;
        rd_resp_rdy[ch] = 1'b1;
        @(posedge clk); #1;
        rd_req_val[ch] = 1'b0;
        got = get_resp(ch);
    endtask

    task automatic wait_init(input string name);
        int cyc;
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (init_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_cmp++;
        if (cyc !== 17) begin
            n_fail++;
            $display("FAIL %s init_done cycle got=%0d exp=17 (0 = never)", name, cyc);
        end
    endtask

    task automatic test_reset();
        logic any_rdy;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({init_done, rd_req_rdy, head_wr_rdy, tail_wr_rdy, new_flow_rdy, rd_resp_val, err_overflow} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0", {init_done, rd_req_rdy, head_wr_rdy, tail_wr_rdy,
                     new_flow_rdy, rd_resp_val, err_overflow});
        end
        n_cmp++;
        if ({rd_resp_addr, rd_resp_head, rd_resp_tail, rd_resp_used, rd_resp_free} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0", {rd_resp_addr, rd_resp_head, rd_resp_tail, rd_resp_used, rd_resp_free});
        end
        rst = 1'b1;
        rd_req_val = 2'b11; new_flow_val = 1'b1; head_wr_val = 1'b1; tail_wr_val = 1'b1;
        new_flow_head = 11'h155; new_flow_tail = 11'h2AA;
        any_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (!init_done) any_rdy |= |{rd_req_rdy, head_wr_rdy, tail_wr_rdy, new_flow_rdy};
            @(posedge clk);
            #0;
        end
        #1;
        rd_req_val = 2'b00; new_flow_val = 1'b0; head_wr_val = 1'b0; tail_wr_val = 1'b0;
        n_cmp++;
        if (any_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_rdy got=%b exp=0", any_rdy);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done_after_sweep got=%b exp=1", init_done);
        end
    endtask

    task automatic test_init_timing();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_init("init_timing");
    endtask

    task automatic test_init_reads();
        logic [48:0] got;
        for (int f = 0; f < 16; f++) begin
            do_read(f % 2, 4'(f), got);
            n_cmp++;
            if (got !== {1'b1, 4'(f), 11'h000, 11'h000, 11'h000, 11'h400}) begin
                n_fail++;
                $display("FAIL init_read flow=%0d got=%h exp=%h", f, got, {1'b1, 4'(f), 33'h0, 11'h400});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_new_flow_prio();
        logic [48:0] got;
        new_flow_val = 1'b1; new_flow_flowid = 4'd5; new_flow_head = 11'h010; new_flow_tail = 11'h010;
        head_wr_val = 1'b1; head_wr_addr = 4'd5; head_wr_data = 11'h123;
        #1;
        n_cmp++;
        if ({new_flow_rdy, head_wr_rdy, tail_wr_rdy} !== 3'b100) begin
            n_fail++;
            $display("FAIL nf_prio_rdy got=%b exp=100", {new_flow_rdy, head_wr_rdy, tail_wr_rdy});
        end
        @(posedge clk); #1;
        new_flow_val = 1'b0; head_wr_val = 1'b0;
        mh[5] = 11'h010; mt[5] = 11'h010;
        do_read(0, 4'd5, got);
        n_cmp++;
        if (got !== {1'b1, 4'd5, 11'h010, 11'h010, 11'h000, 11'h400}) begin
            n_fail++;
            $display("FAIL nf_prio_read got=%h exp=%h", got, {1'b1, 4'd5, 11'h010, 11'h010, 11'h000, 11'h400});
        end
        head_wr_val = 1'b1; head_wr_addr = 4'd6; head_wr_data = 11'h100;
        tail_wr_val = 1'b1; tail_wr_addr = 4'd6; tail_wr_data = 11'h180;
        @(posedge clk); #1;
        head_wr_val = 1'b0; tail_wr_val = 1'b0;
        mh[6] = 11'h100; mt[6] = 11'h180;
        do_read(1, 4'd6, got);
        n_cmp++;
        if (got !== exp_resp(6)) begin
            n_fail++;
            $display("FAIL same_flow_ht got=%h exp=%h", got, exp_resp(6));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fwd_same_cycle();
        logic [48:0] got;
        do_new_flow(4'd3, 11'h010, 11'h010);
        tail_wr_val = 1'b1; tail_wr_addr = 4'd3; tail_wr_data = 11'h030;
        do_read(0, 4'd3, got);
        tail_wr_val = 1'b0;
        mt[3] = 11'h030;
        n_cmp++;
        if (got !== {1'b1, 4'd3, 11'h010, 11'h030, 11'h020, 11'h3E0}) begin
            n_fail++;
            $display("FAIL fwd_same_cycle got=%h exp=%h", got, {1'b1, 4'd3, 11'h010, 11'h030, 11'h020, 11'h3E0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_held_fwd();
        logic [48:0] got;
        do_new_flow(4'd7, 11'h010, 11'h050);
        do_new_flow(4'd2, 11'h100, 11'h120);
        rd_req_val = 2'b11; rd_req_addr = {4'd7, 4'd2}; rd_resp_rdy = 2'b00;
        @(posedge clk); #1;
        rd_req_val = 2'b00;
        head_wr_val = 1'b1; head_wr_addr = 4'd7; head_wr_data = 11'h040;
        @(posedge clk); #1;
        head_wr_val = 1'b0;
        mh[7] = 11'h040;
        for (int i = 0; i < 3; i++) begin
            got = get_resp(1);
            n_cmp++;
            if (got !== {1'b1, 4'd7, 11'h040, 11'h050, 11'h010, 11'h3F0}) begin
                n_fail++;
                $display("FAIL held_fwd_ch1 cyc=%0d got=%h exp=%h", i, got, {1'b1, 4'd7, 11'h040, 11'h050, 11'h010, 11'h3F0});
            end
            got = get_resp(0);
            n_cmp++;
            if (got !== exp_resp(2)) begin
                n_fail++;
                $display("FAIL held_ch0 cyc=%0d got=%h exp=%h", i, got, exp_resp(2));
            end
            n_cmp++;
            if (rd_req_rdy !== 2'b00) begin
                n_fail++;
                $display("FAIL held_req_rdy got=%b exp=00", rd_req_rdy);
            end
            @(posedge clk); #1;
        end
        rd_resp_rdy = 2'b11;
        @(posedge clk); #1;
        n_cmp++;
        if (rd_resp_val !== 2'b00) begin
            n_fail++;
            $display("FAIL held_release got=%b exp=00", rd_resp_val);
        end
    endtask

    task automatic test_back_to_back();
        bit          nf, hw, tw;
        bit   [1:0]  rv, rr, erdy, evld;
        logic [3:0]  nfa, hwa, twa;
        logic [10:0] nfh, nft, hwd, twd;
        logic [3:0]  ra [2];
        int          eflow [2];
        bit          err_seen;
        evld = 2'b00;
        err_seen = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            nf  = ($urandom_range(3) == 0);
            hw  = 1'($urandom_range(1));
            tw  = 1'($urandom_range(1));
            nfa = 4'($urandom_range(15));
            hwa = 4'($urandom_range(15));
            twa = 4'($urandom_range(15));
            nfh = 11'($urandom_range(2047));
            nft = nfh + 11'($urandom_range(1024));
            // Keep occupancy legal so the sticky error stays a meaningful check later.
            if (hw && tw && hwa == twa) begin
                hwd = 11'($urandom_range(2047));
                twd = hwd + 11'($urandom_range(1024));
            end else begin
                hwd = mt[hwa] - 11'($urandom_range(1024));
                twd = mh[twa] + 11'($urandom_range(1024));
            end
            rv = 2'($urandom_range(3));
            rr = 2'($urandom_range(3));
            ra[0] = 4'($urandom_range(15));
            ra[1] = 4'($urandom_range(15));
            new_flow_val = nf; new_flow_flowid = nfa; new_flow_head = nfh; new_flow_tail = nft;
            head_wr_val = hw; head_wr_addr = hwa; head_wr_data = hwd;
            tail_wr_val = tw; tail_wr_addr = twa; tail_wr_data = twd;
            rd_req_val = rv; rd_req_addr = {ra[1], ra[0]}; rd_resp_rdy = rr;
            #1;
            erdy = ~evld | rr;
            n_cmp++;
            if ({new_flow_rdy, head_wr_rdy, tail_wr_rdy, rd_req_rdy} !== {1'b1, ~nf, ~nf, erdy}) begin
                n_fail++;
                $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", cyc,
                         {new_flow_rdy, head_wr_rdy, tail_wr_rdy, rd_req_rdy}, {1'b1, ~nf, ~nf, erdy});
            end
            @(posedge clk); #1;
            if (nf) begin
                mh[nfa] = nfh; mt[nfa] = nft;
            end else begin
                if (hw) mh[hwa] = hwd;
                if (tw) mt[twa] = twd;
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (rv[ch] && erdy[ch]) begin
                    evld[ch] = 1'b1;
                    eflow[ch] = int'(ra[ch]);
                end else if (rr[ch]) begin
                    evld[ch] = 1'b0;
                end
            end
            err_exp |= err_seen;
            err_seen = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                n_cmp++;
                if (rd_resp_val[ch] !== evld[ch]) begin
                    n_fail++;
                    $display("FAIL b2b_val cyc=%0d ch=%0d got=%b exp=%b", cyc, ch, rd_resp_val[ch], evld[ch]);
                end else if (evld[ch]) begin
                    n_cmp++;
                    if (get_resp(ch) !== exp_resp(eflow[ch])) begin
                        n_fail++;
                        $display("FAIL b2b_resp cyc=%0d ch=%0d got=%h exp=%h", cyc, ch, get_resp(ch), exp_resp(eflow[ch]));
                    end
                    if (m_used(eflow[ch]) > 11'h400) err_seen = 1'b1;
                end
            end
            n_cmp++;
            if (err_overflow !== err_exp) begin
                n_fail++;
                $display("FAIL b2b_err cyc=%0d got=%b exp=%b", cyc, err_overflow, err_exp);
            end
        end
        new_flow_val = 1'b0; head_wr_val = 1'b0; tail_wr_val = 1'b0;
        rd_req_val = 2'b00; rd_resp_rdy = 2'b11;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [48:0] got;
        do_new_flow(4'd9, 11'h3F0, 11'h410);
        do_read(0, 4'd9, got);
        n_cmp++;
        if (got !== {1'b1, 4'd9, 11'h3F0, 11'h410, 11'h020, 11'h3E0}) begin
            n_fail++;
            $display("FAIL wrap_used got=%h exp=%h", got, {1'b1, 4'd9, 11'h3F0, 11'h410, 11'h020, 11'h3E0});
        end
        @(posedge clk); #1;
        do_tail_wr(4'd9, 11'h7F0);
        do_read(1, 4'd9, got);
        n_cmp++;
        if (got !== {1'b1, 4'd9, 11'h3F0, 11'h7F0, 11'h400, 11'h000}) begin
            n_fail++;
            $display("FAIL wrap_full got=%h exp=%h", got, {1'b1, 4'd9, 11'h3F0, 11'h7F0, 11'h400, 11'h000});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_err got=%b exp=0", err_overflow);
        end
        do_new_flow(4'd9, 11'h000, 11'h401);
        do_read(0, 4'd9, got);
        n_cmp++;
        if (got !== {1'b1, 4'd9, 11'h000, 11'h401, 11'h401, 11'h7FF}) begin
            n_fail++;
            $display("FAIL ovf_resp got=%h exp=%h", got, {1'b1, 4'd9, 11'h000, 11'h401, 11'h401, 11'h7FF});
        end
        @(posedge clk); #1;
        err_exp = 1'b1;
        repeat (2) begin
            n_cmp++;
            if (err_overflow !== err_exp) begin
                n_fail++;
                $display("FAIL ovf_sticky got=%b exp=%b", err_overflow, err_exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        logic [48:0] got;
        do_new_flow(4'd4, 11'h100, 11'h180);
        rd_req_val = 2'b11; rd_req_addr = {4'd4, 4'd9}; rd_resp_rdy = 2'b00;
        @(posedge clk); #1;
        rd_req_val = 2'b00;
        n_cmp++;
        if (rd_resp_val !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pending got=%b exp=11", rd_resp_val);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({rd_resp_val, init_done, err_overflow, rd_req_rdy, new_flow_rdy} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async got=%b exp=0", {rd_resp_val, init_done, err_overflow, rd_req_rdy, new_flow_rdy});
        end
        rd_resp_rdy = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        err_exp = 1'b0;
        wait_init("mid_reset_sweep");
        do_read(0, 4'd4, got);
        n_cmp++;
        if (got !== exp_resp(4)) begin
            n_fail++;
            $display("FAIL mid_reset_flow4 got=%h exp=%h", got, exp_resp(4));
        end
        do_read(1, 4'd9, got);
        n_cmp++;
        if (got !== exp_resp(9)) begin
            n_fail++;
            $display("FAIL mid_reset_flow9 got=%h exp=%h", got, exp_resp(9));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (err_overflow !== err_exp) begin
            n_fail++;
            $display("FAIL mid_reset_err got=%b exp=%b", err_overflow, err_exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_req_val = '0; rd_req_addr = '0; rd_resp_rdy = '0;
        head_wr_val = 1'b0; head_wr_addr = '0; head_wr_data = '0;
        tail_wr_val = 1'b0; tail_wr_addr = '0; tail_wr_data = '0;
        new_flow_val = 1'b0; new_flow_flowid = '0; new_flow_head = '0; new_flow_tail = '0;
        clear_model();
        test_reset();
        test_init_timing();
        test_init_reads();
        test_new_flow_prio();
        test_fwd_same_cycle();
        test_held_fwd();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
